// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the Memory stage of the 5-stage pipeline.
// A word-addressed RAM sits behind a small wait-state FSM. MemBusy holds the
// pipeline while an access is pending. Load data is presented on ReadData only
// in the completion cycle of an access.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   ADDR_BITS    log2(DEPTH); word index = ALUOutM[ADDR_BITS+1:2]
//   WAIT_STATES  MemBusy cycles per access (0..15). 0 removes the FSM, so
//                reads are combinational and writes commit every edge.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   MemReadM    load request
//   MemWriteM   store request (wins if both requests are high)
//   ALUOutM     byte address (bits [1:0] and bits above ADDR_BITS+1 ignored)
//   WriteDataM  store data
//   ReadData    load data in the completion cycle, 0 otherwise
//   MemBusy     stall request to the hazard unit
//   MemErr      (only with DMEM_CHECK_EN) sticky flag for misaligned or
//               read+write accesses, cleared only by reset
//
// Optional feature macro: DMEM_CHECK_EN
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        MemBusy
`ifdef DMEM_CHECK_EN
    ,
    output logic        MemErr
`endif
);

    logic                 req;
    logic                 is_rd;
    logic                 is_wr;
    logic [ADDR_BITS-1:0] idx;
    logic                 complete;   // cycle in which the access takes effect
    logic                 mem_we;
    logic [31:0]          mem [DEPTH];

    assign req   = MemReadM | MemWriteM;
    assign is_wr = MemWriteM;               // read+write is treated as a write
    assign is_rd = MemReadM & ~MemWriteM;
    assign idx   = ALUOutM[ADDR_BITS+1:2];  // byte offset and high bits dropped

    // Byte offset and upper address bits do not take part in addressing.
    logic unused_addr;
    assign unused_addr = ^{ALUOutM[31:ADDR_BITS+2], ALUOutM[1:0]};

    // Storage is never cleared. A write landing in the same cycle as reset
    // is dropped, which is how an access abandoned by reset is discarded.
    assign mem_we = complete & is_wr & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= WriteDataM;
    end

    // Address is sampled in the completion cycle; the hazard unit keeps it
    // stable for the whole access.
    assign ReadData = (complete && is_rd) ? mem[idx] : 32'h0;

`ifdef DMEM_CHECK_EN
    logic accept;   // access accepted this cycle
`endif

    generate
        if (WAIT_STATES == 0) begin : g_nowait
            // Every cycle is a completion cycle; nothing ever stalls.
            assign complete = 1'b1;
            assign MemBusy  = 1'b0;
`ifdef DMEM_CHECK_EN
            assign accept   = req;
`endif
        end else begin : g_fsm
            typedef enum logic {
                S_IDLE = 1'b0,
                S_WAIT = 1'b1
            } state_t;

            state_t     state;
            state_t     state_nxt;
            logic [3:0] cnt;
            logic [3:0] cnt_nxt;

            // State register
            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                end
            end

            // Next state. The IDLE cycle is itself the first busy cycle, so
            // WAIT starts at N-1 and the access spans N busy cycles plus one
            // completion cycle. A request dropped mid-access keeps counting.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                case (state)
                    S_IDLE: begin
                        if (req) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = 4'(WAIT_STATES - 1);
                        end
                    end
                    S_WAIT: begin
                        if (cnt != 4'd0)
                            cnt_nxt = cnt - 4'd1;
                        else
                            state_nxt = S_IDLE;
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 4'd0;
                    end
                endcase
            end

            // Outputs
            always_comb begin
                MemBusy  = 1'b0;
                complete = 1'b0;
                case (state)
                    S_IDLE: MemBusy = req;
                    S_WAIT: begin
                        MemBusy  = (cnt != 4'd0);
                        complete = (cnt == 4'd0);
                    end
                    default: ;
                endcase
            end

`ifdef DMEM_CHECK_EN
            assign accept = (state == S_IDLE) & req;
`endif
        end
    endgenerate

`ifdef DMEM_CHECK_EN
    // Sticky until reset. The access itself still proceeds normally.
    always_ff @(posedge clk) begin
        if (reset)
            MemErr <= 1'b0;
        else if (accept && ((ALUOutM[1:0] != 2'b00) || (MemReadM && MemWriteM)))
            MemErr <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (WAIT_STATES = 0, 2, 3) on a shared clock with independent
// stimulus. Directed table vectors, hand-written reset/drop sequences, then
// random accesses checked against a word-array model of memory contents.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ND = 3;

    typedef struct {
        int          d;
        bit          w;
        bit          r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [ND];
    logic        rd    [ND];
    logic        wr    [ND];
    logic [31:0] addr  [ND];
    logic [31:0] wdata [ND];
    logic [31:0] rdata [ND];
    logic        busy  [ND];
`ifdef DMEM_CHECK_EN
    logic        err   [ND];
`endif

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            dmem_responder #(
                .DEPTH      (64),
                .ADDR_BITS  (6),
                .WAIT_STATES(g == 0 ? 0 : g + 1)
            ) u_dut (
                .clk       (clk),
                .reset     (rst[g]),
                .MemReadM  (rd[g]),
                .MemWriteM (wr[g]),
                .ALUOutM   (addr[g]),
                .WriteDataM(wdata[g]),
                .ReadData  (rdata[g]),
                .MemBusy   (busy[g])
`ifdef DMEM_CHECK_EN
                ,
                .MemErr    (err[g])
`endif
            );
        end
    endgenerate

    int nvec = 0;
    int nerr = 0;

    // Memory-content model: what each word should hold, and whether it has
    // been written yet (initial RAM contents are undefined).
    logic [31:0] model [ND][64];
    bit          known [ND][64];

    function automatic int ws(int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, act, exp);
        end
    endtask

    // One complete access: WAIT_STATES busy cycles with ReadData=0, then a
    // completion cycle. Entered and left just after a rising edge.
    task automatic access(int d, bit w, bit r, logic [31:0] a, logic [31:0] wd,
                          bit chk_rd, logic [31:0] exp_rd);
        int n = ws(d);
        wr[d] = w; rd[d] = r; addr[d] = a; wdata[d] = wd;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            chk("busy", d, 32'(busy[d]), (c < n) ? 32'd1 : 32'd0);
            if (c < n)
                chk("rdata_busy", d, rdata[d], 32'h0);
            else if (chk_rd)
                chk("rdata", d, rdata[d], exp_rd);
            @(posedge clk); #1;
        end
        if (w) begin
            model[d][widx(a)] = wd;
            known[d][widx(a)] = 1'b1;
        end
        wr[d] = 1'b0; rd[d] = 1'b0;
    endtask

    task automatic idle_check(int d);
        @(negedge clk);
        chk("idle_busy", d, 32'(busy[d]), 32'd0);
        chk("idle_rdata", d, rdata[d], 32'h0);
        @(posedge clk); #1;
    endtask

    vec_t tbl [16];

    initial begin
        tbl = '{
            '{0, 1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0},
            '{0, 1'b0, 1'b1, 32'h10,       32'h0,        32'hDEADBEEF},
            '{0, 1'b0, 1'b1, 32'h113,      32'h0,        32'hDEADBEEF},
            '{1, 1'b1, 1'b0, 32'h04,       32'h12345678, 32'h0},
            '{1, 1'b0, 1'b1, 32'h04,       32'h0,        32'h12345678},
            '{1, 1'b1, 1'b0, 32'h08,       32'hA5A5A5A5, 32'h0},
            '{1, 1'b0, 1'b1, 32'h08,       32'h0,        32'hA5A5A5A5},
            '{1, 1'b1, 1'b0, 32'h00,       32'h00000011, 32'h0},
            '{1, 1'b0, 1'b1, 32'h100,      32'h0,        32'h00000011},
            '{1, 1'b0, 1'b1, 32'h03,       32'h0,        32'h00000011},
            '{1, 1'b1, 1'b1, 32'h0C,       32'hCAFEF00D, 32'h0},
            '{1, 1'b0, 1'b1, 32'h0C,       32'h0,        32'hCAFEF00D},
            '{1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000077, 32'h0},
            '{1, 1'b0, 1'b1, 32'hFC,       32'h0,        32'h00000077},
            '{2, 1'b1, 1'b0, 32'h20,       32'h0BADF00D, 32'h0},
            '{2, 1'b0, 1'b1, 32'h22,       32'h0,        32'h0BADF00D}
        };

        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0;
            for (int i = 0; i < 64; i++) known[d][i] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
            chk("rst_rdata", d, rdata[d], 32'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;

        // Directed vectors; consecutive entries on one DUT run back-to-back
        for (int i = 0; i < 16; i++)
            access(tbl[i].d, tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata,
                   1'b1, tbl[i].exp);

        // Reset in the 2nd busy cycle of a write: write must be discarded
        wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hFFFFFFFF;
        @(negedge clk); chk("abort_busy0", 2, 32'(busy[2]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("abort_busy1", 2, 32'(busy[2]), 32'd1);
        rst[2] = 1'b1; wr[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 2, 32'(busy[2]), 32'd0);
        chk("abort_rdata_after", 2, rdata[2], 32'h0);
        @(posedge clk); #1;
        access(2, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h0BADF00D);

        // Write dropped while waiting: counting continues, nothing commits
        access(1, 1'b1, 1'b0, 32'h30, 32'h00000055, 1'b1, 32'h0);
        wr[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h00000099;
        @(negedge clk); chk("drop_busy0", 1, 32'(busy[1]), 32'd1);
        @(posedge clk); #1;
        wr[1] = 1'b0;
        @(negedge clk); chk("drop_busy1", 1, 32'(busy[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop_busy2", 1, 32'(busy[1]), 32'd0);
        chk("drop_rdata", 1, rdata[1], 32'h0);
        @(posedge clk); #1;
        idle_check(1);
        access(1, 1'b0, 1'b1, 32'h30, 32'h0, 1'b1, 32'h00000055);

        // Random accesses against the memory model
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 60; k++) begin
                int          op = int'($urandom_range(0, 3));
                bit          w  = (op >= 2);
                bit          r  = (op != 2);
                logic [31:0] a  = $urandom;
                logic [31:0] wd = $urandom;
                bit          c  = w || known[d][widx(a)];
                logic [31:0] e  = (!w && known[d][widx(a)]) ? model[d][widx(a)] : 32'h0;
                access(d, w, r, a, wd, c, e);
                if ($urandom_range(0, 3) == 0) idle_check(d);
            end
        end

`ifdef DMEM_CHECK_EN
        // Error flag: set by a misaligned access, sticky until reset
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk); chk("err_rst", 1, 32'(err[1]), 32'd0);
        @(posedge clk); #1;
        access(1, 1'b0, 1'b1, 32'h04, 32'h0, 1'b0, 32'h0);
        @(negedge clk); chk("err_clean", 1, 32'(err[1]), 32'd0);
        @(posedge clk); #1;
        access(1, 1'b0, 1'b1, 32'h06, 32'h0, 1'b0, 32'h0);
        @(negedge clk); chk("err_set", 1, 32'(err[1]), 32'd1);
        @(posedge clk); #1;
        access(1, 1'b0, 1'b1, 32'h04, 32'h0, 1'b0, 32'h0);
        @(negedge clk); chk("err_sticky", 1, 32'(err[1]), 32'd1);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk); chk("err_cleared", 1, 32'(err[1]), 32'd0);
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage pipelined datapath.
- Services the Memory-stage load/store requests and returns ReadData to the M->W pipeline register.
- Supports a configurable number of wait states. MemBusy requests a pipeline stall while an access is pending, feeding the hazard unit alongside StallF/StallD.
- Word-addressed synchronous RAM plus a wait-state FSM.

Parameters:
- DEPTH, 64: number of 32-bit words; power of two.
- ADDR_BITS, 6: log2(DEPTH); word index = ALUOutM[ADDR_BITS+1:2].
- WAIT_STATES, 2: number of MemBusy cycles per access, range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- MemReadM  input  1  load request from Memory stage.
- MemWriteM  input  1  store request from Memory stage.
- ALUOutM  input  32  byte address.
- WriteDataM  input  32  store data.
- ReadData  output  32  load data, valid in the completion cycle.
- MemBusy  output  1  stall request to hazard unit; pipeline holds M-stage inputs stable while high.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, cnt 0, ReadData 0, MemBusy 0. RAM contents are not cleared. Reset mid-access abandons the access; a pending write is discarded.
- req = MemReadM | MemWriteM. Both high is treated as a write.
- Addressing:
  - ALUOutM[1:0] ignored.
  - Bits above ADDR_BITS+1 ignored (address wraps modulo DEPTH).
- WAIT_STATES = 0 (no FSM activity, MemBusy tied 0):
  - Read: ReadData = mem[idx] combinationally in the same cycle.
  - Write: commits at the clock edge ending the cycle.
- WAIT_STATES = N > 0, FSM states IDLE and WAIT, counter cnt (4 bits):
  - IDLE, req=0: MemBusy=0, ReadData=0.
  - IDLE, req=1: MemBusy=1; cnt <= N-1; -> WAIT.
  - WAIT, cnt != 0: MemBusy=1; cnt <= cnt-1.
  - WAIT, cnt == 0 (completion cycle): MemBusy=0.
    - Read: ReadData = mem[idx].
    - Write: mem[idx] <= WriteDataM at the edge.
    - Next state IDLE.
- Latency: exactly N MemBusy cycles, then 1 completion cycle; N+1 cycles per access.
- Back-to-back: a new request seen in IDLE the cycle after completion starts a fresh access; there is no idle bubble inside the block.
- Outside the completion cycle, ReadData = 0.
- Request dropped while in WAIT (MemReadM/MemWriteM fall to 0):
  - Counting continues.
  - On completion no write commits, ReadData = 0, return to IDLE.
- Address/data are sampled in the completion cycle, not at acceptance. The hazard unit guarantees they are stable.

Optional Feature:
- Macro DMEM_CHECK_EN.
- Defined:
  - Adds output MemErr (1 bit), a registered, sticky error flag cleared only by reset.
  - Sets on an access accepted (IDLE with req=1, or completion when N=0) where ALUOutM[1:0] != 0, or where MemReadM & MemWriteM.
  - The access still proceeds as described above.
- Undefined: port MemErr absent; these conditions are handled silently as described above.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x10, next cycle read 0x10 -> ReadData=0xDEADBEEF same cycle, MemBusy never 1.
2. WAIT_STATES=2: read 0x04 after storing 0x12345678 -> MemBusy=1 for exactly 2 cycles, 3rd cycle MemBusy=0 and ReadData=0x12345678; ReadData=0 in the busy cycles.
3. WAIT_STATES=2: write 0xA5A5A5A5 to 0x08, read 0x08 back-to-back -> 6 cycles total, MemBusy pattern 1,1,0,1,1,0, read returns 0xA5A5A5A5.
4. DEPTH=64: write 0x11 to 0x00, read 0x100 -> returns 0x11 (wrap); read 0x03 -> returns 0x11 (low bits ignored).
5. WAIT_STATES=3: assert reset in the 2nd busy cycle of a write of 0xFFFFFFFF to 0x20 -> next cycle MemBusy=0, IDLE; subsequent read of 0x20 returns the prior value.
6. DMEM_CHECK_EN: read at 0x06 -> MemErr=1 from the following cycle, stays 1 through later valid accesses until reset.
